execute_stage: RTL and testbench

//  Execute stage of the 5-stage RV32 pipeline. It consumes the decode->execute register outputs and sits upstream of the execute->memory register.

---
 rtl/execute_stage_if.sv | 51 +++++
 rtl/execute_stage.sv | 149 ++++++++++++++
 tb/tb_execute_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage_if
//  Brief    : Bundle of decode->execute operands, forwarding sources and
//             execute-stage results for the RV32 execute stage.
//  Revision : 1.0  initial release
// ============================================================================
interface execute_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                  BranchE_i;
    logic                  JumpE_i;
    logic [2:0]            ALUControlE_i;
    logic                  ALUSrcE_i;
    logic                  MdEnE_i;
    logic [1:0]            MdOpE_i;
    logic [DATA_WIDTH-1:0] RD1E_i;
    logic [DATA_WIDTH-1:0] RD2E_i;
    logic [DATA_WIDTH-1:0] ImmExtE_i;
    logic [PC_WIDTH-1:0]   PCE_i;
    logic [1:0]            ForwardAE_i;
    logic [1:0]            ForwardBE_i;
    logic [DATA_WIDTH-1:0] ResultW_i;
    logic [DATA_WIDTH-1:0] ALUResultM_i;
    logic [DATA_WIDTH-1:0] ALUResultE_o;
    logic [DATA_WIDTH-1:0] WriteDataE_o;
    logic [PC_WIDTH-1:0]   PCTargetE_o;
    logic                  PCSrcE_o;
    logic                  ZeroE_o;
    logic                  MdBusyE_o;

    // Upstream side: decode register, forwarding network and hazard unit
    modport master (
        output BranchE_i, JumpE_i, ALUControlE_i, ALUSrcE_i, MdEnE_i, MdOpE_i,
        output RD1E_i, RD2E_i, ImmExtE_i, PCE_i, ForwardAE_i, ForwardBE_i,
        output ResultW_i, ALUResultM_i,
        input  ALUResultE_o, WriteDataE_o, PCTargetE_o, PCSrcE_o, ZeroE_o,
        input  MdBusyE_o
    );

    // Execute stage side
    modport slave (
        input  BranchE_i, JumpE_i, ALUControlE_i, ALUSrcE_i, MdEnE_i, MdOpE_i,
        input  RD1E_i, RD2E_i, ImmExtE_i, PCE_i, ForwardAE_i, ForwardBE_i,
        input  ResultW_i, ALUResultM_i,
        output ALUResultE_o, WriteDataE_o, PCTargetE_o, PCSrcE_o, ZeroE_o,
        output MdBusyE_o
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage
//  Brief    : RV32 execute stage - operand forwarding, single-cycle ALU,
//             branch/jump resolution and an iterative unsigned mul/div unit
//             that stalls the front of the pipeline while it runs.
//  Revision : 1.0  initial release
// ============================================================================
module execute_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int PC_WIDTH      = 32,
    parameter int MD_ITERATIONS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    execute_stage_if.slave  bus
);

    localparam int c_CW  = $clog2(MD_ITERATIONS);
    localparam int c_SHW = $clog2(DATA_WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(MD_ITERATIONS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [DATA_WIDTH-1:0]   w_fwd_a;
    logic [DATA_WIDTH-1:0]   w_fwd_b;
    logic [DATA_WIDTH-1:0]   w_src_b;
    logic [DATA_WIDTH-1:0]   w_alu_result;
    logic [DATA_WIDTH-1:0]   w_md_result;

    logic [1:0]              r_state;
    logic [c_CW-1:0]         r_count;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic [1:0]              r_md_op;

    logic [c_CW-1:0]         w_bit_idx;
    logic [2*DATA_WIDTH-1:0] w_mul_next;
    logic [DATA_WIDTH:0]     w_rem_sh;
    logic [DATA_WIDTH:0]     w_rem_sub;
    logic                    w_rem_ge;
    logic [2*DATA_WIDTH-1:0] w_div_next;

    // Forwarding muxes; encoding 11 falls back to the register file value
    always_comb begin
        w_fwd_a = bus.RD1E_i;
        w_fwd_b = bus.RD2E_i;
        case (bus.ForwardAE_i)
            2'b01:   w_fwd_a = bus.ResultW_i;
            2'b10:   w_fwd_a = bus.ALUResultM_i;
            default: w_fwd_a = bus.RD1E_i;
        endcase
        case (bus.ForwardBE_i)
            2'b01:   w_fwd_b = bus.ResultW_i;
            2'b10:   w_fwd_b = bus.ALUResultM_i;
            default: w_fwd_b = bus.RD2E_i;
        endcase
    end

    assign w_src_b = bus.ALUSrcE_i ? bus.ImmExtE_i : w_fwd_b;

    // Single-cycle ALU; shifts use only the low log2(DW) bits of SrcB
    always_comb begin
        w_alu_result = '0;
        case (bus.ALUControlE_i)
            3'b000: w_alu_result = w_fwd_a + w_src_b;
            3'b001: w_alu_result = w_fwd_a - w_src_b;
            3'b010: w_alu_result = w_fwd_a & w_src_b;
            3'b011: w_alu_result = w_fwd_a | w_src_b;
            3'b100: w_alu_result = w_fwd_a ^ w_src_b;
            3'b101: w_alu_result = {{(DATA_WIDTH-1){1'b0}},
                                    ($signed(w_fwd_a) < $signed(w_src_b))};
            3'b110: w_alu_result = w_fwd_a << w_src_b[c_SHW-1:0];
            default: w_alu_result = w_fwd_a >> w_src_b[c_SHW-1:0];
        endcase
    end

    // One iteration of shift-add multiply (MSB first) and restoring divide.
    // Multiply keeps the full product in r_acc; divide keeps the remainder
    // in the upper half and the quotient in the lower half, so both pick
    // their result with MdOp[0]. A zero divisor always "fits", giving an
    // all-ones quotient and the dividend as remainder with no special case.
    always_comb begin
        w_bit_idx  = c_LAST - r_count;
        w_mul_next = {r_acc[2*DATA_WIDTH-2:0], 1'b0} +
                     (r_op_b[w_bit_idx] ? {{DATA_WIDTH{1'b0}}, r_op_a}
                                        : {(2*DATA_WIDTH){1'b0}});
        w_rem_sh   = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_op_a[w_bit_idx]};
        w_rem_sub  = w_rem_sh - {1'b0, r_op_b};
        w_rem_ge   = (w_rem_sh >= {1'b0, r_op_b});
        w_div_next = {(w_rem_ge ? w_rem_sub[DATA_WIDTH-1:0]
                                : w_rem_sh[DATA_WIDTH-1:0]),
                      r_acc[DATA_WIDTH-2:0], w_rem_ge};
    end

    assign w_md_result = r_md_op[0] ? r_acc[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : r_acc[DATA_WIDTH-1:0];

    // Mul/div sequencer: latch operands in IDLE, iterate in RUN, present in DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
            r_acc   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_md_op <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.MdEnE_i) begin
                        r_op_a  <= w_fwd_a;
                        r_op_b  <= w_fwd_b;
                        r_md_op <= bus.MdOpE_i;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!bus.MdEnE_i) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc   <= r_md_op[1] ? w_div_next : w_mul_next;
                        r_count <= r_count + 1'b1;
                        if (r_count == c_LAST) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ALUResultE_o = (r_state == c_ST_DONE) ? w_md_result : w_alu_result;
    assign bus.WriteDataE_o = w_fwd_b;
    assign bus.PCTargetE_o  = bus.PCE_i + PC_WIDTH'(bus.ImmExtE_i);
    assign bus.ZeroE_o      = (w_alu_result == '0);
    assign bus.PCSrcE_o     = (bus.BranchE_i & bus.ZeroE_o) | bus.JumpE_i;
    assign bus.MdBusyE_o    = ~rst_i & bus.MdEnE_i & (r_state != c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_stage
//  Brief    : Directed self-checking bench for execute_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    execute_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) ex_if ();

    execute_stage #(
        .DATA_WIDTH    (32),
        .PC_WIDTH      (32),
        .MD_ITERATIONS (32)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ex_if.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        ex_if.BranchE_i     = 1'b0;
        ex_if.JumpE_i       = 1'b0;
        ex_if.ALUControlE_i = 3'b000;
        ex_if.ALUSrcE_i     = 1'b0;
        ex_if.MdEnE_i       = 1'b0;
        ex_if.MdOpE_i       = 2'b00;
        ex_if.RD1E_i        = '0;
        ex_if.RD2E_i        = '0;
        ex_if.ImmExtE_i     = '0;
        ex_if.PCE_i         = '0;
        ex_if.ForwardAE_i   = 2'b00;
        ex_if.ForwardBE_i   = 2'b00;
        ex_if.ResultW_i     = '0;
        ex_if.ALUResultM_i  = '0;
    endtask

    // Issue one mul/div op from a negedge; counts busy cycles, checks the
    // DONE-cycle result, and returns on the negedge after DONE.
    task automatic md_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit keep, input bit glitch);
        int cnt;
        cnt = 0;
        ex_if.RD1E_i      = a;
        ex_if.RD2E_i      = b;
        ex_if.ForwardAE_i = 2'b00;
        ex_if.ForwardBE_i = 2'b00;
        ex_if.ALUSrcE_i   = 1'b0;
        ex_if.MdOpE_i     = op;
        ex_if.MdEnE_i     = 1'b1;
        #1;
        while (ex_if.MdBusyE_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
            if (glitch && cnt == 5) begin
                ex_if.RD1E_i = 32'hDEAD_BEEF;
                ex_if.RD2E_i = 32'h0000_1234;
            end
        end
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'd33);
        chk({tag, "_result"}, ex_if.ALUResultE_o, exp);
        if (!keep) ex_if.MdEnE_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_defaults();

        // Reset with a mul/div request present: busy must stay low
        rst = 1'b1;
        ex_if.MdEnE_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, ex_if.MdBusyE_o}, 32'd0);
        ex_if.MdEnE_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Forwarding into ALU with immediate operand
        ex_if.RD1E_i = 32'd5; ex_if.ALUResultM_i = 32'd7; ex_if.ResultW_i = 32'd20;
        ex_if.ImmExtE_i = 32'd3; ex_if.ALUSrcE_i = 1'b1; ex_if.ALUControlE_i = 3'b000;
        ex_if.ForwardAE_i = 2'b10; #1;
        chk("fwd_mem_add", ex_if.ALUResultE_o, 32'd10);
        ex_if.ForwardAE_i = 2'b01; #1;
        chk("fwd_wb_add", ex_if.ALUResultE_o, 32'd23);
        ex_if.ForwardAE_i = 2'b11; #1;
        chk("fwd_11_add", ex_if.ALUResultE_o, 32'd8);

        // Store data forwarding and register-register ALU ops
        ex_if.ForwardAE_i = 2'b00; ex_if.ALUSrcE_i = 1'b0;
        ex_if.RD2E_i = 32'd99; ex_if.ForwardBE_i = 2'b10; #1;
        chk("store_fwd_mem", ex_if.WriteDataE_o, 32'd7);
        ex_if.ForwardBE_i = 2'b00;
        ex_if.RD1E_i = 32'hF0F0_00FF; ex_if.RD2E_i = 32'h0FF0_0F0F;
        ex_if.ALUControlE_i = 3'b010; #1;
        chk("alu_and", ex_if.ALUResultE_o, 32'h00F0_000F);
        ex_if.ALUControlE_i = 3'b011; #1;
        chk("alu_or", ex_if.ALUResultE_o, 32'hFFF0_0FFF);
        ex_if.ALUControlE_i = 3'b100; #1;
        chk("alu_xor", ex_if.ALUResultE_o, 32'hFF00_0FF0);
        ex_if.RD1E_i = 32'hFFFF_FFFF; ex_if.RD2E_i = 32'd1; ex_if.ALUControlE_i = 3'b101; #1;
        chk("alu_slt_signed", ex_if.ALUResultE_o, 32'd1);
        ex_if.RD1E_i = 32'd0; ex_if.RD2E_i = 32'd1; ex_if.ALUControlE_i = 3'b001; #1;
        chk("alu_sub_wrap", ex_if.ALUResultE_o, 32'hFFFF_FFFF);
        ex_if.RD1E_i = 32'd1; ex_if.RD2E_i = 32'h21; ex_if.ALUControlE_i = 3'b110; #1;
        chk("alu_sll_5bit", ex_if.ALUResultE_o, 32'd2);
        ex_if.RD1E_i = 32'h8000_0000; ex_if.RD2E_i = 32'd4; ex_if.ALUControlE_i = 3'b111; #1;
        chk("alu_srl", ex_if.ALUResultE_o, 32'h0800_0000);

        // Branch resolution
        ex_if.BranchE_i = 1'b1; ex_if.ALUControlE_i = 3'b001;
        ex_if.RD1E_i = 32'd9; ex_if.RD2E_i = 32'd9;
        ex_if.PCE_i = 32'h100; ex_if.ImmExtE_i = 32'h20; #1;
        chk("beq_zero", {31'd0, ex_if.ZeroE_o}, 32'd1);
        chk("beq_taken", {31'd0, ex_if.PCSrcE_o}, 32'd1);
        chk("beq_target", ex_if.PCTargetE_o, 32'h120);
        ex_if.RD2E_i = 32'd8; #1;
        chk("beq_not_taken", {31'd0, ex_if.PCSrcE_o}, 32'd0);
        ex_if.BranchE_i = 1'b0; ex_if.JumpE_i = 1'b1; #1;
        chk("jal_taken", {31'd0, ex_if.PCSrcE_o}, 32'd1);
        set_defaults();
        @(negedge clk);

        // Multiply; MULHU also has its inputs disturbed mid-run
        md_op("mul_lo", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        md_op("mulhu", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1'b1);
        md_op("mul_big", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 1'b0);

        // Divide, including divide by zero
        md_op("divu", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        md_op("remu", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        md_op("divu_by0", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        md_op("remu_by0", 2'b11, 32'd55, 32'd0, 32'd55, 1'b0, 1'b0);

        // Back-to-back: DIVU held through DONE, MUL starts from the following IDLE
        md_op("b2b_divu", 2'b10, 32'd1000, 32'd10, 32'd100, 1'b1, 1'b0);
        md_op("b2b_mul", 2'b00, 32'd12, 32'd13, 32'd156, 1'b0, 1'b0);

        // Flush mid-RUN aborts; a fresh op must take the full latency
        ex_if.RD1E_i = 32'd3; ex_if.RD2E_i = 32'd5; ex_if.MdOpE_i = 2'b00; ex_if.MdEnE_i = 1'b1;
        repeat (5) @(negedge clk);
        ex_if.MdEnE_i = 1'b0; #1;
        chk("flush_busy", {31'd0, ex_if.MdBusyE_o}, 32'd0);
        @(negedge clk);
        md_op("post_flush_mul", 2'b00, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0);

        // Reset at RUN cycle 10 discards the op
        ex_if.RD1E_i = 32'd77; ex_if.RD2E_i = 32'd0; ex_if.MdOpE_i = 2'b10; ex_if.MdEnE_i = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1; #1;
        chk("rst_mid_run_busy", {31'd0, ex_if.MdBusyE_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ex_if.MdEnE_i = 1'b0;
        @(negedge clk);
        md_op("post_rst_divu", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
